// File: rtl/efuse_array_n.sv
// WIDTH-bit e-fuse macro model: sense into FO, serial scan chain, bit-serial blow with abort and sticky ERR.
// Define EFUSE_LOCK_EN to make fuse bit WIDTH-1 a lock that rejects further blows.
module efuse_array_n #(
  parameter int              WIDTH     = 32,
  parameter int              SENSE_CYC = 4,
  parameter int              BLOW_CYC  = 8,
  parameter logic [WIDTH-1:0] FUSE_INIT = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             SEL,
  input  logic             SM,
  input  logic             SI,
  input  logic             WE,
  input  logic             SENSE,
  input  logic             VBLOW,
  output logic [WIDTH-1:0] FO,
  output logic             SO,
  output logic             SENSO,
  output logic             BUSY,
  output logic             ERR
);

  localparam int IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int MAXC = (SENSE_CYC > BLOW_CYC) ? SENSE_CYC : BLOW_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SENSE, S_BLOW} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Non-volatile array: initial contents only, never touched by RSTN.
  logic [WIDTH-1:0] r_fuse_q = FUSE_INIT;
  logic [WIDTH-1:0] r_fo;
  logic [WIDTH-1:0] r_sr;
  logic             r_senso;
  logic             r_err;
  logic             r_sense_q;
  logic             r_we_q;
  logic             r_sel;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;

  logic w_sense_rise, w_we_rise, w_accept, w_sense_go, w_we_go;
  logic w_lock, w_blow_go, w_blow_rej, w_need, w_bit_last;
  logic w_blow_abort, w_last_idx, w_sense_done, w_blow_fire;

`ifdef EFUSE_LOCK_EN
  assign w_lock = r_fuse_q[WIDTH-1];
`else
  assign w_lock = 1'b0;
`endif

  assign w_sense_rise = SENSE & ~r_sense_q;
  assign w_we_rise    = WE & ~r_we_q;
  assign w_accept     = EN & ~SM & (r_state == S_IDLE);
  assign w_sense_go   = w_accept & w_sense_rise;
  assign w_we_go      = w_accept & w_we_rise & ~w_sense_rise;
  assign w_blow_go    = w_we_go & VBLOW & ~w_lock;
  assign w_blow_rej   = w_we_go & ~(VBLOW & ~w_lock);
  assign w_need       = r_sr[r_idx] & ~r_fuse_q[r_idx];
  assign w_bit_last   = ~w_need | (r_cnt == CW'(BLOW_CYC - 1));
  assign w_blow_abort = ~VBLOW | ~EN;
  assign w_last_idx   = (r_idx == IW'(WIDTH - 1));
  assign w_sense_done = (r_cnt == CW'(SENSE_CYC));
  // Abort wins over the final blow cycle, so an interrupted bit is never set.
  assign w_blow_fire  = (r_state == S_BLOW) & ~w_blow_abort & w_need &
                        (r_cnt == CW'(BLOW_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sense_go)     w_state_nxt = S_SENSE;
        else if (w_blow_go) w_state_nxt = S_BLOW;
      end
      S_SENSE: if (!EN || w_sense_done) w_state_nxt = S_IDLE;
      S_BLOW:  if (w_blow_abort || (w_bit_last && w_last_idx)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (r_state != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_fo      <= '0;
      r_sr      <= '0;
      r_senso   <= 1'b0;
      r_err     <= 1'b0;
      r_sense_q <= 1'b0;
      r_we_q    <= 1'b0;
      r_sel     <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_sense_q <= SENSE;
      r_we_q    <= WE;
      r_senso   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (EN && SM) r_sr <= {r_sr[WIDTH-2:0], SI};
          if (w_sense_go) begin
            r_cnt <= CW'(1);
            r_sel <= SEL;
            r_err <= 1'b0;
          end else if (w_blow_go) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
          end else if (w_blow_rej) begin
            r_err <= 1'b1;
          end
        end
        S_SENSE: begin
          if (EN) begin
            if (w_sense_done) begin
              r_fo    <= r_fuse_q;
              r_senso <= 1'b1;
              if (r_sel) r_sr <= r_fuse_q;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_BLOW: begin
          if (w_blow_abort) begin
            r_err <= 1'b1;
          end else if (w_bit_last) begin
            r_cnt <= '0;
            if (!w_last_idx) r_idx <= r_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && w_blow_fire) r_fuse_q[r_idx] <= 1'b1;
  end

  assign FO    = r_fo;
  assign SO    = r_sr[WIDTH-1];
  assign SENSO = r_senso;
  assign ERR   = r_err;

endmodule
